// File: rtl/byte_unstriping.sv
// byte_unstriping: merges two skewed 32-bit lanes back into one ordered stream via per-lane FIFOs.
module byte_unstriping #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int REALIGN_CYCLES = 4
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] lane_0,
  input  logic                  valid_0,
  input  logic [DATA_WIDTH-1:0] lane_1,
  input  logic                  valid_1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  overflow_0,
  output logic                  overflow_1
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(REALIGN_CYCLES + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] IMAX = IW'(REALIGN_CYCLES);
  logic [DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] din [2];
  logic [AW-1:0] wp [2];
  logic [AW-1:0] rp [2];
  logic [AW:0] cnt [2];
  logic [1:0] vin, pop, push, drop;
  logic sel, idle;
  logic [IW-1:0] idle_cnt;
  // a full FIFO still accepts a word when its head leaves in the same cycle
  always_comb begin
    din[0] = lane_0;
    din[1] = lane_1;
    vin = {valid_1, valid_0};
    pop = sel ? {cnt[1] != '0, 1'b0} : {1'b0, cnt[0] != '0};
    for (int i = 0; i < 2; i++) begin
      push[i] = vin[i] && (cnt[i] != FULL || pop[i]);
      drop[i] = vin[i] && !push[i];
    end
    idle = cnt[0] == '0 && cnt[1] == '0 && vin == 2'b00;
  end
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
        cnt[i] <= '0;
      end
      sel <= 1'b0;
      idle_cnt <= '0;
      data_out <= '0;
      valid_out <= 1'b0;
      overflow_0 <= 1'b0;
      overflow_1 <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wp[i]] <= din[i];
          wp[i] <= wp[i] + AW'(1);
        end
        if (pop[i]) rp[i] <= rp[i] + AW'(1);
        cnt[i] <= cnt[i] + (AW + 1)'(push[i]) - (AW + 1)'(pop[i]);
      end
      overflow_0 <= overflow_0 | drop[0];
      overflow_1 <= overflow_1 | drop[1];
      valid_out <= |pop;
      data_out <= |pop ? mem[sel][rp[sel]] : '0;
      sel <= |pop ? !sel : (idle_cnt == IMAX ? 1'b0 : sel);
      idle_cnt <= !idle ? '0 : (idle_cnt == IMAX ? idle_cnt : idle_cnt + IW'(1));
    end
  end
endmodule

// File: tb/tb_byte_unstriping.sv
// tb_byte_unstriping: directed vector table plus randomized traffic against a queue-based model.
module tb_byte_unstriping;
  localparam int DEPTH = 4;
  localparam int RC = 4;
  typedef struct {
    bit rst;
    bit v0;
    logic [31:0] d0;
    bit v1;
    logic [31:0] d1;
    logic [31:0] ed;
    bit o0;
    bit o1;
  } vec_t;
  logic clk_2f = 1'b0;
  logic reset, valid_0, valid_1;
  logic [31:0] lane_0, lane_1, data_out;
  logic valid_out, overflow_0, overflow_1;
  int total = 0, bad = 0, cyc = 0;
  vec_t vecs[$];
  logic [31:0] q0[$], q1[$];
  bit m_sel, m_v, m_ov0, m_ov1;
  int m_idle;
  logic [31:0] m_d;

  byte_unstriping #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .REALIGN_CYCLES(RC)) dut (
    .clk_2f(clk_2f), .reset(reset), .lane_0(lane_0), .valid_0(valid_0),
    .lane_1(lane_1), .valid_1(valid_1), .data_out(data_out), .valid_out(valid_out),
    .overflow_0(overflow_0), .overflow_1(overflow_1));

  always #5 clk_2f = ~clk_2f;

  task automatic add(input bit r, v0, input logic [31:0] d0, input bit v1,
                     input logic [31:0] d1, ed, input bit o0, o1);
    vec_t v;
    v.rst = r; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ed = ed; v.o0 = o0; v.o1 = o1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] a, e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask

  task automatic drive(input bit r, v0, input logic [31:0] d0, input bit v1, input logic [31:0] d1);
    reset = r; valid_0 = v0; lane_0 = d0; valid_1 = v1; lane_1 = d1;
  endtask

  task automatic step();
    @(posedge clk_2f);
    #1;
    cyc++;
  endtask

  // stream-level reference: two word queues, a turn flag and an idle run length
  task automatic model(input bit r, v0, input logic [31:0] d0, input bit v1, input logic [31:0] d1);
    int n0, n1;
    bit t0, t1;
    if (r) begin
      q0.delete(); q1.delete();
      m_sel = 0; m_idle = 0; m_d = 0; m_v = 0; m_ov0 = 0; m_ov1 = 0;
      return;
    end
    n0 = q0.size(); n1 = q1.size();
    t0 = !m_sel && n0 > 0;
    t1 = m_sel && n1 > 0;
    m_v = t0 || t1;
    m_d = 0;
    if (t0) m_d = q0.pop_front();
    if (t1) m_d = q1.pop_front();
    if (v0) begin
      if (n0 < DEPTH || t0) q0.push_back(d0);
      else m_ov0 = 1;
    end
    if (v1) begin
      if (n1 < DEPTH || t1) q1.push_back(d1);
      else m_ov1 = 1;
    end
    if (m_v) m_sel = !m_sel;
    else if (m_idle == RC) m_sel = 0;
    if (n0 == 0 && n1 == 0 && !v0 && !v1) m_idle = m_idle < RC ? m_idle + 1 : m_idle;
    else m_idle = 0;
  endtask

  initial begin
    int p0, p1;
    bit r, v0, v1;
    logic [31:0] d0, d1;
    // balanced stream
    add(1,0,0,0,0,0,0,0);
    add(0,1,32'hA0000000,1,32'hA0000001,0,0,0);
    add(0,0,0,0,0,32'hA0000000,0,0);
    add(0,1,32'hA0000002,1,32'hA0000003,32'hA0000001,0,0);
    add(0,0,0,0,0,32'hA0000002,0,0);
    add(0,1,32'hA0000004,1,32'hA0000005,32'hA0000003,0,0);
    add(0,0,0,0,0,32'hA0000004,0,0);
    add(0,0,0,0,0,32'hA0000005,0,0);
    // lane 1 skewed three cycles late
    add(0,1,32'h11111111,0,0,0,0,0);
    add(0,0,0,0,0,32'h11111111,0,0);
    add(0,1,32'h33333333,0,0,0,0,0);
    add(0,0,0,1,32'h22222222,0,0,0);
    add(0,0,0,0,0,32'h22222222,0,0);
    add(0,0,0,1,32'h44444444,32'h33333333,0,0);
    add(0,0,0,0,0,32'h44444444,0,0);
    // lane 0 overflow while lane 1 is silent
    add(1,0,0,0,0,0,0,0);
    add(0,1,32'hB0000000,0,0,0,0,0);
    add(0,1,32'hB0000001,0,0,32'hB0000000,0,0);
    add(0,1,32'hB0000002,0,0,0,0,0);
    add(0,1,32'hB0000003,0,0,0,0,0);
    add(0,1,32'hB0000004,0,0,0,0,0);
    add(0,1,32'hB0000005,0,0,0,1,0);
    add(0,0,0,1,32'hC0000000,0,1,0);
    add(0,0,0,0,0,32'hC0000000,1,0);
    add(0,0,0,0,0,32'hB0000001,1,0);
    add(0,0,0,0,0,0,1,0);
    // full FIFO pushed while popped
    add(1,0,0,0,0,0,0,0);
    add(0,1,32'hD0000000,0,0,0,0,0);
    add(0,1,32'hD0000001,0,0,32'hD0000000,0,0);
    add(0,1,32'hD0000002,0,0,0,0,0);
    add(0,1,32'hD0000003,0,0,0,0,0);
    add(0,1,32'hD0000004,0,0,0,0,0);
    add(0,0,0,1,32'hE0000000,0,0,0);
    add(0,0,0,0,0,32'hE0000000,0,0);
    add(0,1,32'hD0000005,0,0,32'hD0000001,0,0);
    add(0,0,0,1,32'hE0000001,0,0,0);
    add(0,0,0,1,32'hE0000002,32'hE0000001,0,0);
    add(0,0,0,0,0,32'hD0000002,0,0);
    add(0,0,0,0,0,32'hE0000002,0,0);
    add(0,0,0,0,0,32'hD0000003,0,0);
    add(0,0,0,1,32'hE0000003,0,0,0);
    add(0,0,0,0,0,32'hE0000003,0,0);
    add(0,0,0,0,0,32'hD0000004,0,0);
    add(0,0,0,1,32'hE0000004,0,0,0);
    add(0,0,0,0,0,32'hE0000004,0,0);
    add(0,0,0,0,0,32'hD0000005,0,0);
    // realign after four idle cycles
    add(1,0,0,0,0,0,0,0);
    add(0,1,32'hF0000000,1,32'hF0000001,0,0,0);
    add(0,1,32'hF0000002,0,0,32'hF0000000,0,0);
    add(0,0,0,0,0,32'hF0000001,0,0);
    add(0,0,0,0,0,32'hF0000002,0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0,0,0,0,0);
    add(0,1,32'hAAAA0000,1,32'hBBBB0000,0,0,0);
    add(0,0,0,0,0,32'hAAAA0000,0,0);
    add(0,0,0,0,0,32'hBBBB0000,0,0);
    // only three idle cycles: no realign
    add(0,1,32'h60000000,0,0,0,0,0);
    add(0,0,0,0,0,32'h60000000,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,0,0,0);
    add(0,1,32'hAAAA0000,1,32'hBBBB0000,0,0,0);
    add(0,0,0,0,0,32'hBBBB0000,0,0);
    add(0,0,0,0,0,32'hAAAA0000,0,0);
    // reset with words buffered and pushes pending
    add(0,1,32'h70000000,0,0,0,0,0);
    add(0,1,32'h70000002,0,0,0,0,0);
    add(0,1,32'h70000004,1,32'h70000001,0,0,0);
    add(1,1,32'h70000006,1,32'h70000003,0,0,0);
    add(0,1,32'h90000000,1,32'h90000001,0,0,0);
    add(0,0,0,0,0,32'h90000000,0,0);
    add(0,0,0,0,0,32'h90000001,0,0);
    add(0,0,0,0,0,0,0,0);
    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].v0, vecs[k].d0, vecs[k].v1, vecs[k].d1);
      step();
      chk("vec_data", data_out, vecs[k].ed);
      chk("vec_valid", {31'b0, valid_out}, {31'b0, vecs[k].ed != 0});
      chk("vec_ovf0", {31'b0, overflow_0}, {31'b0, vecs[k].o0});
      chk("vec_ovf1", {31'b0, overflow_1}, {31'b0, vecs[k].o1});
    end
    drive(1, 0, 0, 0, 0);
    model(1, 0, 0, 0, 0);
    step();
    p0 = 50; p1 = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        p0 = $urandom_range(0, 100);
        p1 = $urandom_range(0, 100);
      end
      r = $urandom_range(0, 299) == 0;
      v0 = $urandom_range(0, 99) < p0;
      v1 = $urandom_range(0, 99) < p1;
      d0 = $urandom;
      d1 = $urandom;
      drive(r, v0, d0, v1, d1);
      model(r, v0, d0, v1, d1);
      step();
      chk("rnd_data", data_out, m_d);
      chk("rnd_valid", {31'b0, valid_out}, {31'b0, m_v});
      chk("rnd_ovf0", {31'b0, overflow_0}, {31'b0, m_ov0});
      chk("rnd_ovf1", {31'b0, overflow_1}, {31'b0, m_ov1});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
